bus_arb: RTL

BUS_ARB -- requirements
Module: bus_arb

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/bus_arb_rr.sv | 22 ++
 rtl/bus_arb.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus arbiter: FSM state encoding,
// memory-bus direction values and requester indices.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

endpackage

// File: rtl/bus_arb_rr.sv
// Two-way round-robin pick. A lone request always wins; on a tie the
// requester that was not granted last wins. Output is one-hot (or zero).
module rr_arb2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  // tie-break on the last-granted index, otherwise pass the lone request through
  always_comb begin
    pick = 2'b00;
    if (req == 2'b11) begin
      if (last == 1'(REQ_DMA)) pick = 2'b01;
      else                     pick = 2'b10;
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/bus_arb.sv
// Two-requester (CPU, DMA) arbiter for a single external memory bus.
// Each access runs ADDR -> WAIT x WAIT_CYCLES -> DONE; DONE can chain
// straight into the next ADDR when a request is pending.
// Optional build macro BUS_ARB_RDY_EN adds a mem_rdy input that can stretch
// the WAIT phase until the memory reports ready.
//
//   state | meaning
//   IDLE  | bus released, gnt = 0, waiting for any request
//   ADDR  | address/direction driven for the granted requester
//   WAIT  | wait states, 4-bit down-counter runs to zero
//   DONE  | ack to owner, read data taken from din
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef BUS_ARB_RDY_EN
  input  logic        mem_rdy,
`endif
  input  logic [1:0]  req,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic [7:0]  rdata,
  output logic [15:0] addrbus,
  output logic        rw,
  output logic [7:0]  dout,
  output logic        dout_oe,
  input  logic [7:0]  din
);

  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        last;
  logic [1:0]  pick;
  logic        take;
  logic        rdy;
  logic        busy;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        we_q;

`ifdef BUS_ARB_RDY_EN
  assign rdy = mem_rdy;
`else
  assign rdy = 1'b1;
`endif

  rr_arb2 u_rr (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  // state and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // next-state, counter load/decrement and grant strobe
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    take         = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = ADDR;
          take      = 1'b1;
        end
      end
      ADDR: begin
        // with no wait states a not-ready memory still parks us in WAIT
        if (HAS_WAIT || !rdy) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = WAIT_LOAD;
        end else begin
          state_nxt = DONE;
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          if (rdy) state_nxt = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      DONE: begin
        // the owner's own req during its ack cycle counts as a fresh request
        if (|req) begin
          state_nxt = ADDR;
          take      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant, round-robin history and latched access parameters
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= 2'b00;
      last    <= 1'(REQ_DMA);
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      if (take) begin
        gnt     <= pick;
        last    <= pick[REQ_DMA];
        addr_q  <= pick[REQ_DMA] ? addr1  : addr0;
        wdata_q <= pick[REQ_DMA] ? wdata1 : wdata0;
        we_q    <= pick[REQ_DMA] ? we1    : we0;
      end else if (state == DONE) begin
        gnt <= 2'b00;
      end
      if (state == DONE && !we_q) rdata_q <= din;
    end
  end

  // bus outputs; rdata shows din directly in the ack cycle, then holds it
  assign busy    = (state != IDLE);
  assign ack     = (state == DONE) ? gnt : 2'b00;
  assign rdata   = (state == DONE && !we_q) ? din : rdata_q;
  assign addrbus = addr_q;
  assign rw      = (busy && we_q) ? RW_WRITE : RW_READ;
  assign dout    = wdata_q;
  assign dout_oe = busy && we_q;

endmodule
